led_matrix_scan_ctrl: RTL and testbench
=======================================

// Module: led_matrix_scan_ctrl
// PURPOSE
// Scan sequencer for the pong LED matrix. Drives the column shift register
// (CSDI/CCLK/LE), the row walking-one register (RSDI/RCLK) and the shared
// output enable (OEB), mprj_io[26:21]. Fetches one row per scan slot from the
// game framebuffer and time-multiplexes all rows continuously. Sits between
// the framebuffer and the IO pads.
// PARAMETERS
// ROWS    8   matrix rows; row counter width RW = $clog2(ROWS)
// COLS    8   matrix columns; framebuffer word width
// CLKDIV  2   shift-clock half period, in clock cycles (>=1)
// HOLD    16  display on-time per row, in clock cycles (>=1)
// PORTS
// clock     in   1     system clock
// resetb    in   1     asynchronous active-low reset
// enable    in   1     run scanning; sampled only at frame boundary / in IDLE
// blank     in   1     force display off (OEB=1) without stopping the scan
// fb_row    out  RW    framebuffer row address
// fb_data   in   COLS  row pixels, valid 1 cycle after fb_row (registered read)
// csdi      out  1     column serial data, MSB (bit COLS-1) shifted first
// cclk      out  1     column shift clock
// le        out  1     column latch enable
// rsdi      out  1     row serial data (walking one)
// rclk      out  1     row shift clock
// oeb       out  1     output enable, active low
// frame_done out 1     1-cycle pulse, last cycle of final row's DISPLAY
// BEHAVIOUR
// - All outputs registered. Reset: fb_row=0, csdi=cclk=le=rsdi=rclk=0,
//   frame_done=0, oeb=1, state=IDLE, row=0; applies immediately mid-operation.
// - IDLE: oeb=1; if enable=1 -> FETCH with row=0.
// - FETCH (2 cyc): cyc0 fb_row=row; cyc1 capture fb_data into shift reg.
// - SHIFT (2*CLKDIV*COLS cyc): per bit, csdi updated on first cycle of low
//   phase, cclk=0 for CLKDIV cycles then 1 for CLKDIV; bit COLS-1 first.
//   Previous row stays lit (oeb unchanged) while shifting.
// - BLANK (1 cyc): oeb=1.
// - RSTEP (2*CLKDIV cyc): rsdi=(row==0); rclk=1 for first CLKDIV, 0 for next.
//   rsdi returns to 0 on exit.
// - LATCH (CLKDIV cyc): le=1; le=0 on exit.
// - DISPLAY (HOLD cyc): oeb=blank. Last cycle: if row==ROWS-1 pulse
//   frame_done, row wraps to 0, then FETCH if enable else IDLE; otherwise
//   row+1 -> FETCH.
// - Row period T = 3 + 2*CLKDIV*COLS + 3*CLKDIV + HOLD (defaults: 57);
//   frame = ROWS*T (defaults: 456 cycles). First oeb=0 at cycle 2+32+1+4+2=41
//   after leaving IDLE.
// - enable deasserted mid-frame: frame completes, then IDLE (oeb=1).
// - blank: oeb=1 from the cycle after blank=1 in any state; sequencing,
//   counters and frame_done unaffected; removal re-lights only in DISPLAY.
// - fb_data sampled only in FETCH cyc1; changes elsewhere ignored.
// - row counter never exceeds ROWS-1; ROWS non-power-of-2 wraps at ROWS-1.
// TESTING
// 1 Reset: resetb=0 mid-SHIFT -> next edge oeb=1, cclk=le=rclk=csdi=rsdi=0,
//   fb_row=0; release with enable=1 -> fb_row=0 one cycle later.
// 2 Column data: fb_data=8'hA5 for row 0 -> 8 cclk rising edges, csdi sampled
//   at rising edges = 1,0,1,0,0,1,0,1; le pulse 2 cycles after rclk falls.
// 3 Row walk: full frame -> rsdi=1 at rclk rising edge only for row 0; exactly
//   8 rclk pulses; fb_row sequence 0..7 then 0.
// 4 Timing: defaults -> frame_done pulses every 456 cycles, width 1; oeb=0 for
//   16 cycles per row, 41 cycles after leaving IDLE for row 0.
// 5 Enable drop: enable=0 during row 3 -> rows 4..7 still scanned, frame_done
//   once, then IDLE with oeb=1 and no further cclk/rclk.
// 6 Blank: blank=1 during DISPLAY -> oeb=1 next cycle, frame_done period
//   still 456; blank=0 -> oeb=0 next cycle if still in DISPLAY.

Source files
------------

// File: rtl/led_matrix_scan_ctrl.sv
// Scan sequencer for the pong LED matrix: fetches one framebuffer row per slot,
// shifts it into the column register, steps the row walking-one and lights it.
module led_matrix_scan_ctrl #(
    parameter int unsigned ROWS   = 8,
    parameter int unsigned COLS   = 8,
    parameter int unsigned CLKDIV = 2,
    parameter int unsigned HOLD   = 16
) (
    input  logic                     clock,
    input  logic                     resetb,
    input  logic                     enable,
    input  logic                     blank,
    output logic [$clog2(ROWS)-1:0]  fb_row,
    input  logic [COLS-1:0]          fb_data,
    output logic                     csdi,
    output logic                     cclk,
    output logic                     le,
    output logic                     rsdi,
    output logic                     rclk,
    output logic                     oeb,
    output logic                     frame_done
);

    localparam int unsigned RW        = $clog2(ROWS);
    localparam int unsigned BW        = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned SHIFT_LEN = 2 * CLKDIV;
    localparam int unsigned CNT_MAX   = (HOLD > SHIFT_LEN) ? HOLD : SHIFT_LEN;
    localparam int unsigned CW        = $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_BLANK,
        S_RSTEP,
        S_LATCH,
        S_DISP
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [BW-1:0]   r_bit;
    logic [RW-1:0]   r_row;
    logic [COLS-1:0] r_shreg;
    logic [RW-1:0]   r_fb_row;
    logic            r_csdi;
    logic            r_cclk;
    logic            r_le;
    logic            r_rsdi;
    logic            r_rclk;
    logic            r_oeb;
    logic            r_frame_done;

    logic [CW-1:0]   w_cnt_inc;
    logic            w_row_last;
    logic [RW-1:0]   w_row_next;
    logic            w_bit_last;

    assign w_cnt_inc  = r_cnt + CW'(1);
    assign w_row_last = (r_row == RW'(ROWS - 1));
    assign w_row_next = w_row_last ? '0 : r_row + RW'(1);
    assign w_bit_last = (r_bit == BW'(COLS - 1));

    // Outputs are assigned on the edge that enters the cycle they describe.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_row        <= '0;
            r_shreg      <= '0;
            r_fb_row     <= '0;
            r_csdi       <= 1'b0;
            r_cclk       <= 1'b0;
            r_le         <= 1'b0;
            r_rsdi       <= 1'b0;
            r_rclk       <= 1'b0;
            r_oeb        <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            // Hold the current lit/dark state; blank always forces dark.
            r_oeb        <= r_oeb | blank;
            case (r_state)
                S_IDLE: begin
                    r_oeb <= 1'b1;
                    if (enable) begin
                        r_state  <= S_FETCH;
                        r_cnt    <= '0;
                        r_row    <= '0;
                        r_fb_row <= '0;
                    end
                end
                S_FETCH: begin
                    if (r_cnt == '0) begin
                        r_cnt <= w_cnt_inc;
                    end else begin
                        r_shreg <= fb_data;
                        r_csdi  <= fb_data[COLS-1];
                        r_cclk  <= 1'b0;
                        r_bit   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == CW'(SHIFT_LEN - 1)) begin
                        r_cnt  <= '0;
                        r_cclk <= 1'b0;
                        if (w_bit_last) begin
                            r_state <= S_BLANK;
                            r_oeb   <= 1'b1;
                        end else begin
                            // Rotate so the next bit is always just below the MSB.
                            r_bit   <= r_bit + BW'(1);
                            r_shreg <= {r_shreg[COLS-2:0], r_shreg[COLS-1]};
                            r_csdi  <= r_shreg[COLS-2];
                        end
                    end else begin
                        r_cnt  <= w_cnt_inc;
                        r_cclk <= (w_cnt_inc >= CW'(CLKDIV));
                    end
                end
                S_BLANK: begin
                    r_oeb   <= 1'b1;
                    r_state <= S_RSTEP;
                    r_cnt   <= '0;
                    r_rclk  <= 1'b1;
                    r_rsdi  <= (r_row == '0);
                end
                S_RSTEP: begin
                    r_oeb <= 1'b1;
                    if (r_cnt == CW'(SHIFT_LEN - 1)) begin
                        r_state <= S_LATCH;
                        r_cnt   <= '0;
                        r_rsdi  <= 1'b0;
                        r_rclk  <= 1'b0;
                        r_le    <= 1'b1;
                    end else begin
                        r_cnt  <= w_cnt_inc;
                        r_rclk <= (w_cnt_inc < CW'(CLKDIV));
                    end
                end
                S_LATCH: begin
                    r_oeb <= 1'b1;
                    if (r_cnt == CW'(CLKDIV - 1)) begin
                        r_le         <= 1'b0;
                        r_state      <= S_DISP;
                        r_cnt        <= '0;
                        r_oeb        <= blank;
                        r_frame_done <= (HOLD == 1) && w_row_last;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_DISP: begin
                    if (r_cnt == CW'(HOLD - 1)) begin
                        r_cnt    <= '0;
                        r_row    <= w_row_next;
                        r_fb_row <= w_row_next;
                        if (w_row_last && !enable) begin
                            r_state <= S_IDLE;
                            r_oeb   <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end else begin
                        r_cnt        <= w_cnt_inc;
                        r_oeb        <= blank;
                        r_frame_done <= w_row_last && (w_cnt_inc == CW'(HOLD - 1));
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_oeb   <= 1'b1;
                end
            endcase
        end
    end

    assign fb_row     = r_fb_row;
    assign csdi       = r_csdi;
    assign cclk       = r_cclk;
    assign le         = r_le;
    assign rsdi       = r_rsdi;
    assign rclk       = r_rclk;
    assign oeb        = r_oeb;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Directed bench for led_matrix_scan_ctrl with default parameters: vector table
// over the first frame plus sequences for enable drop, blank and reset.
module tb_led_matrix_scan_ctrl;

    logic       clock = 1'b0;
    logic       resetb;
    logic       enable;
    logic       blank;
    logic [2:0] fb_row;
    logic [7:0] fb_data;
    logic       csdi, cclk, le, rsdi, rclk, oeb, frame_done;

    always #5 clock = ~clock;

    led_matrix_scan_ctrl dut (
        .clock      (clock),
        .resetb     (resetb),
        .enable     (enable),
        .blank      (blank),
        .fb_row     (fb_row),
        .fb_data    (fb_data),
        .csdi       (csdi),
        .cclk       (cclk),
        .le         (le),
        .rsdi       (rsdi),
        .rclk       (rclk),
        .oeb        (oeb),
        .frame_done (frame_done)
    );

    // Registered-read framebuffer
    logic [7:0] fb_mem [8];
    always @(posedge clock) fb_data <= fb_mem[fb_row];

    typedef struct {
        int         cyc;
        logic [2:0] row;
        logic       oeb, cclk, csdi, le, rclk, rsdi, fd;
    } vec_t;

    vec_t tv[$];

    int n_pass = 0;
    int n_total = 0;
    int cyc;
    int s_cclk, s_rclk, s_le, s_oeb_low, s_oeb_fall, s_fd, s_fd_cyc;
    logic [7:0] s_col, s_rpat;
    logic p_cclk, p_rclk, p_le, p_oeb;

    localparam logic [9:0] RESET_VEC = 10'b000_1_000000;

    function automatic logic [9:0] outv();
        return {fb_row, oeb, cclk, csdi, le, rclk, rsdi, frame_done};
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic clear_stats();
        s_cclk = 0; s_rclk = 0; s_le = 0; s_oeb_low = 0; s_oeb_fall = 0;
        s_fd = 0; s_fd_cyc = -1; s_col = '0; s_rpat = '0;
        p_cclk = cclk; p_rclk = rclk; p_le = le; p_oeb = oeb;
    endtask

    // Advance one clock, sample on the falling edge and accumulate edge statistics
    task automatic step();
        @(posedge clock);
        @(negedge clock);
        cyc++;
        if (cclk && !p_cclk) begin
            s_cclk++;
            if (s_cclk <= 8) s_col = {s_col[6:0], csdi};
        end
        if (rclk && !p_rclk) begin
            s_rclk++;
            s_rpat = {s_rpat[6:0], rsdi};
        end
        if (le && !p_le) s_le++;
        if (!oeb) s_oeb_low++;
        if (!oeb && p_oeb) s_oeb_fall++;
        if (frame_done) begin
            s_fd++;
            s_fd_cyc = cyc;
        end
        p_cclk = cclk; p_rclk = rclk; p_le = le; p_oeb = oeb;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        resetb = 1'b0;
        enable = 1'b0;
        blank  = 1'b0;
        cyc    = 0;
        fb_mem[0] = 8'hA5; fb_mem[1] = 8'h3C; fb_mem[2] = 8'h81; fb_mem[3] = 8'h7E;
        fb_mem[4] = 8'h0F; fb_mem[5] = 8'hF0; fb_mem[6] = 8'h55; fb_mem[7] = 8'h12;

        //            cyc  row  oeb cclk csdi le rclk rsdi fd
        tv.push_back('{  0, 3'd0, 1, 0, 0, 0, 0, 0, 0});
        tv.push_back('{  1, 3'd0, 1, 0, 0, 0, 0, 0, 0});
        tv.push_back('{  2, 3'd0, 1, 0, 1, 0, 0, 0, 0});
        tv.push_back('{  4, 3'd0, 1, 1, 1, 0, 0, 0, 0});
        tv.push_back('{  6, 3'd0, 1, 0, 0, 0, 0, 0, 0});
        tv.push_back('{  8, 3'd0, 1, 1, 0, 0, 0, 0, 0});
        tv.push_back('{ 10, 3'd0, 1, 0, 1, 0, 0, 0, 0});
        tv.push_back('{ 14, 3'd0, 1, 0, 0, 0, 0, 0, 0});
        tv.push_back('{ 31, 3'd0, 1, 0, 1, 0, 0, 0, 0});
        tv.push_back('{ 33, 3'd0, 1, 1, 1, 0, 0, 0, 0});
        tv.push_back('{ 34, 3'd0, 1, 0, 1, 0, 0, 0, 0});
        tv.push_back('{ 35, 3'd0, 1, 0, 1, 0, 1, 1, 0});
        tv.push_back('{ 36, 3'd0, 1, 0, 1, 0, 1, 1, 0});
        tv.push_back('{ 37, 3'd0, 1, 0, 1, 0, 0, 1, 0});
        tv.push_back('{ 39, 3'd0, 1, 0, 1, 1, 0, 0, 0});
        tv.push_back('{ 40, 3'd0, 1, 0, 1, 1, 0, 0, 0});
        tv.push_back('{ 41, 3'd0, 0, 0, 1, 0, 0, 0, 0});
        tv.push_back('{ 56, 3'd0, 0, 0, 1, 0, 0, 0, 0});
        tv.push_back('{ 57, 3'd1, 0, 0, 1, 0, 0, 0, 0});
        tv.push_back('{ 59, 3'd1, 0, 0, 0, 0, 0, 0, 0});
        tv.push_back('{ 91, 3'd1, 1, 0, 0, 0, 0, 0, 0});
        tv.push_back('{ 92, 3'd1, 1, 0, 0, 0, 1, 0, 0});
        tv.push_back('{ 98, 3'd1, 0, 0, 0, 0, 0, 0, 0});
        tv.push_back('{399, 3'd7, 0, 0, 1, 0, 0, 0, 0});
        tv.push_back('{455, 3'd7, 0, 0, 0, 0, 0, 0, 1});

        repeat (3) @(negedge clock);
        check("reset_state", int'(outv()), int'(RESET_VEC));

        // Frame 0: enable sampled on the next edge, which is cycle 0 of FETCH
        resetb = 1'b1;
        enable = 1'b1;
        cyc    = -1;
        clear_stats();
        foreach (tv[i]) begin
            step_to(tv[i].cyc);
            check($sformatf("vec_c%0d", tv[i].cyc), int'(outv()),
                  int'({tv[i].row, tv[i].oeb, tv[i].cclk, tv[i].csdi, tv[i].le,
                        tv[i].rclk, tv[i].rsdi, tv[i].fd}));
        end
        check("cclk_rises", s_cclk, 64);
        check("row0_col_bits", int'(s_col), 32'hA5);
        check("rclk_rises", s_rclk, 8);
        check("rsdi_pattern", int'(s_rpat), 32'h80);
        check("le_pulses", s_le, 8);
        check("oeb_low_cycles", s_oeb_low, 366);
        check("oeb_fall_edges", s_oeb_fall, 8);
        check("frame_done_count", s_fd, 1);
        check("frame_done_cycle", s_fd_cyc, 455);

        step_to(456);
        check("wrap_fb_row", int'(fb_row), 0);
        check("wrap_oeb_held", int'(oeb), 0);
        step_to(458);
        check("frame1_first_bit", int'({cclk, csdi}), 1);

        // Enable dropped during row 3 of frame 1
        step_to(637);
        enable = 1'b0;
        clear_stats();
        step_to(911);
        check("drop_frame_done_count", s_fd, 1);
        check("drop_frame_done_cycle", s_fd_cyc, 911);
        check("drop_rclk_rises", s_rclk, 5);
        step_to(912);
        check("idle_oeb", int'(oeb), 1);
        check("idle_fb_row", int'(fb_row), 0);
        clear_stats();
        step_to(1012);
        check("idle_no_clocks", s_cclk + s_rclk, 0);
        check("idle_oeb_low", s_oeb_low, 0);

        // Blank during DISPLAY and during SHIFT, restart from IDLE
        enable = 1'b1;
        cyc    = -1;
        clear_stats();
        step_to(45);
        blank = 1'b1;
        step();
        check("blank_disp_oeb", int'(oeb), 1);
        step_to(50);
        blank = 1'b0;
        step();
        check("unblank_disp_oeb", int'(oeb), 0);
        step_to(60);
        blank = 1'b1;
        step();
        check("blank_shift_oeb", int'(oeb), 1);
        step_to(65);
        blank = 1'b0;
        step();
        check("unblank_shift_stays_dark", int'(oeb), 1);
        step_to(98);
        check("row1_display_lit", int'(oeb), 0);
        step_to(455);
        check("blank_frame_done_count", s_fd, 1);
        check("blank_frame_done_cycle", s_fd_cyc, 455);

        // Asynchronous reset in the middle of a SHIFT high phase
        step_to(461);
        check("pre_reset_cclk", int'({cclk, oeb}), 2);
        resetb = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("mid_shift_reset", int'(outv()), int'(RESET_VEC));
        resetb = 1'b1;
        cyc    = -1;
        clear_stats();
        step();
        check("restart_c0", int'(outv()), int'(RESET_VEC));
        step_to(2);
        check("restart_first_bit", int'({fb_row, cclk, csdi}), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
